// File: rtl/control_fsm.sv
// Multicycle MIPS-style main control unit: Moore FSM sequencing fetch,
// decode and per-class execute/writeback, with branch write-enable steering.
module control_fsm (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] Opcode,
  output logic       PC_EN,
  output logic       PCWrite_BEQ,
  output logic       PCWrite_BNE,
  output logic       PCWrite_BLEZ,
  output logic       PCWrite_BGTZ,
  output logic       PCWrite_BLTZ,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic [3:0] STATE
);

  localparam int unsigned STATE_W = 4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BLTZ  = 6'b000001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  // Kept as a plain vector so unused codes 12-15 are representable and recover.
  logic [STATE_W-1:0] state_q;
  state_t             state_d;

  assign STATE = state_q;

  // State register; reset returns to FETCH immediately.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= STATE_W'(S_FETCH);
    end else begin
      state_q <= STATE_W'(state_d);
    end
  end

  // Next-state and Moore output decode; every strobe is held low while in reset.
  always_comb begin
    state_d      = S_FETCH;
    PC_EN        = 1'b0;
    PCWrite_BEQ  = 1'b0;
    PCWrite_BNE  = 1'b0;
    PCWrite_BLEZ = 1'b0;
    PCWrite_BGTZ = 1'b0;
    PCWrite_BLTZ = 1'b0;
    IorD         = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    ALUOp        = 2'b00;
    PCSrc        = 2'b00;

    case (state_q)
      S_FETCH: begin
        state_d = S_DECODE;
        ALUSrcB = 2'b01;
        IRWrite = 1'b1;
        PC_EN   = 1'b1;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW:                              state_d = S_MEMADR;
          OP_RTYPE:                                  state_d = S_RTYPEEX;
          OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_BLTZ: state_d = S_BRANCH;
          OP_ADDI:                                   state_d = S_ADDIEX;
          OP_J:                                      state_d = S_JUMP;
          default:                                   state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (Opcode == OP_LW) begin
          state_d = S_MEMRD;
        end else if (Opcode == OP_SW) begin
          state_d = S_MEMWR;
        end
      end
      S_MEMRD: begin
        state_d = S_MEMWB;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_RTYPEEX: begin
        state_d = S_RTYPEWB;
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RTYPEWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        case (Opcode)
          OP_BEQ:  PCWrite_BEQ  = 1'b1;
          OP_BNE:  PCWrite_BNE  = 1'b1;
          OP_BLEZ: PCWrite_BLEZ = 1'b1;
          OP_BGTZ: PCWrite_BGTZ = 1'b1;
          OP_BLTZ: PCWrite_BLTZ = 1'b1;
          default: ;
        endcase
      end
      S_ADDIEX: begin
        state_d = S_ADDIWB;
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_ADDIWB: begin
        RegWrite = 1'b1;
      end
      S_JUMP: begin
        PCSrc = 2'b10;
        PC_EN = 1'b1;
      end
      default: ;
    endcase

    // Reset suppresses every strobe; the register itself is already at FETCH.
    if (!RST) begin
      PC_EN        = 1'b0;
      PCWrite_BEQ  = 1'b0;
      PCWrite_BNE  = 1'b0;
      PCWrite_BLEZ = 1'b0;
      PCWrite_BGTZ = 1'b0;
      PCWrite_BLTZ = 1'b0;
      IorD         = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      RegDst       = 1'b0;
      MemtoReg     = 1'b0;
      RegWrite     = 1'b0;
      ALUSrcA      = 1'b0;
      ALUSrcB      = 2'b00;
      ALUOp        = 2'b00;
      PCSrc        = 2'b00;
    end
  end

endmodule
